// File: rtl/fetch_stage.sv
// fetch_stage: PC register and one-entry IF/ID register in front of a
// combinational instruction ROM, with valid/ready back-pressure,
// redirect/flush, and a halt -> drain -> halted sequence.
module fetch_stage #(
    parameter int unsigned             PC_WIDTH    = 8,
    parameter int unsigned             INSTR_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic                   if_valid,
    input  logic                   id_ready,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    input  logic                   halt,
    output logic                   halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e                 state_q,    state_d;
    logic [PC_WIDTH-1:0]    pc_q,       pc_d;
    logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
    logic [PC_WIDTH-1:0]    if_pc_q,    if_pc_d;
    logic                   if_valid_q, if_valid_d;
    logic                   halted_q,   halted_d;

    logic transfer_c;

    // Downstream consumes the held instruction at this edge.
    assign transfer_c = if_valid_q & id_ready;

    // Next-state and datapath: redirect first, then per-state fetch/drain behaviour.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;

        if (redirect) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
            state_d    = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (halt) begin
                        // Stop fetching; a same-edge transfer still empties the register.
                        state_d = ST_DRAIN;
                        if (transfer_c) begin
                            if_valid_d = 1'b0;
                        end
                    end else if (!if_valid_q || id_ready) begin
                        if_instr_d = instruction;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + PC_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!if_valid_q || transfer_c) begin
                        if_valid_d = 1'b0;
                        state_d    = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    // Only redirect or reset leave this state.
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        halted_d = (state_d == ST_HALTED);
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign pc       = pc_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign if_valid = if_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a ROM model feeds the DUT, every
// downstream handshake is checked against a queue of expected (pc, instr)
// pairs, and per-cycle register state is checked after each edge.
module tb_fetch_stage;

    logic       clk;
    logic       reset;
    logic [7:0] pc;
    logic [7:0] instruction;
    logic [7:0] if_instr;
    logic [7:0] if_pc;
    logic       if_valid;
    logic       id_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halt;
    logic       halted;

    logic [7:0]  rom [256];
    logic [15:0] sb [$];
    int n_checks;
    int n_fail;

    fetch_stage #(
        .PC_WIDTH   (8),
        .INSTR_WIDTH(8),
        .RESET_PC   (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instruction(instruction),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .id_ready   (id_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .halted     (halted)
    );

    assign instruction = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect a transfer of (addr, rom[addr]) at some later edge.
    task automatic push(input logic [7:0] addr);
        sb.push_back({addr, rom[addr]});
    endtask

    // One clock: check any handshake about to happen, then step to the next falling edge.
    task automatic tick();
        logic [15:0] e;
        if (!reset && if_valid === 1'b1 && id_ready) begin
            n_checks++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_xfer: observed if_pc %0h expected no transfer", if_pc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("xfer", {16'h0, if_pc, if_instr}, {16'h0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] e_pc, input logic e_valid,
                            input logic e_halted);
        chk({tag, "_pc"},     {24'h0, pc},       {24'h0, e_pc});
        chk({tag, "_valid"},  {31'h0, if_valid}, {31'h0, e_valid});
        chk({tag, "_halted"}, {31'h0, halted},   {31'h0, e_halted});
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_ifpc);
        chk({tag, "_if_pc"},    {24'h0, if_pc},    {24'h0, e_ifpc});
        chk({tag, "_if_instr"}, {24'h0, if_instr}, {24'h0, rom[e_ifpc]});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 5) ^ (i >> 3));
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;

        reset = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        @(negedge clk);
        tick(); tick();
        chk_regs("reset", 8'h00, 1'b0, 1'b0);
        chk("reset_if_instr", {24'h0, if_instr}, 32'h0);
        chk("reset_if_pc",    {24'h0, if_pc},    32'h0);

        // Stream from reset, then back-pressure on 8'h22.
        reset = 1'b0;
        push(8'h00); push(8'h01);
        tick();
        chk_out("s0", 8'h00); chk_regs("s0", 8'h01, 1'b1, 1'b0);
        tick();
        chk_out("s1", 8'h01); chk_regs("s1", 8'h02, 1'b1, 1'b0);
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall", 8'h01); chk_regs("stall", 8'h02, 1'b1, 1'b0);
        end
        id_ready = 1'b1;
        push(8'h02); push(8'h03); push(8'h04);
        tick(); chk_out("s2", 8'h02);
        tick(); chk_out("s3", 8'h03);
        tick(); chk_out("s4", 8'h04);

        // Redirect with a same-edge transfer, then wrap-around.
        redirect = 1'b1; redirect_pc = 8'hFE;
        tick();
        redirect = 1'b0;
        chk_regs("redir", 8'hFE, 1'b0, 1'b0);
        push(8'hFE); push(8'hFF); push(8'h00);
        tick(); chk_out("w0", 8'hFE); chk_regs("w0", 8'hFF, 1'b1, 1'b0);
        tick(); chk_out("w1", 8'hFF); chk_regs("w1", 8'h00, 1'b1, 1'b0);
        tick(); chk_out("w2", 8'h00); chk_regs("w2", 8'h01, 1'b1, 1'b0);
        tick(); chk_out("w3", 8'h01); chk_regs("w3", 8'h02, 1'b1, 1'b0);

        // Redirect under stall: the stalled 8'h01 is flushed, never transferred.
        id_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h80;
        tick();
        redirect = 1'b0; id_ready = 1'b1;
        chk_regs("rstall", 8'h80, 1'b0, 1'b0);
        tick();
        chk_out("rstall_t", 8'h80); chk_regs("rstall_t", 8'h81, 1'b1, 1'b0);

        // Move to address 4 and stall on 5, then halt.
        push(8'h80); redirect = 1'b1; redirect_pc = 8'h04;
        tick();
        redirect = 1'b0;
        push(8'h04);
        tick(); chk_out("h4", 8'h04);
        tick(); chk_out("h5", 8'h05); chk_regs("h5", 8'h06, 1'b1, 1'b0);
        id_ready = 1'b0; halt = 1'b1;
        tick();
        chk_out("drain", 8'h05); chk_regs("drain", 8'h06, 1'b1, 1'b0);
        halt = 1'b0;
        tick(); chk_regs("drain2", 8'h06, 1'b1, 1'b0);
        tick(); chk_regs("drain3", 8'h06, 1'b1, 1'b0);
        id_ready = 1'b1; push(8'h05);
        tick();
        chk_regs("halted", 8'h06, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            halt = 1'(i % 2); id_ready = 1'(i % 3 == 0);
            tick();
            chk_regs("hold", 8'h06, 1'b0, 1'b1);
        end
        halt = 1'b0; id_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 8'h06;
        tick();
        redirect = 1'b0;
        chk_regs("resume", 8'h06, 1'b0, 1'b0);
        push(8'h06);
        tick(); chk_out("resume_t", 8'h06); chk_regs("resume_t", 8'h07, 1'b1, 1'b0);

        // Halt and redirect together: redirect wins and fetch continues.
        halt = 1'b1; redirect = 1'b1; redirect_pc = 8'h10;
        tick();
        halt = 1'b0; redirect = 1'b0;
        chk_regs("hr", 8'h10, 1'b0, 1'b0);
        push(8'h10);
        tick(); chk_out("hr_t", 8'h10); chk_regs("hr_t", 8'h11, 1'b1, 1'b0);

        // Halt with a same-edge transfer: drained immediately, halted one edge later.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk_regs("hx_drain", 8'h11, 1'b0, 1'b0);
        tick(); chk_regs("hx_halted", 8'h11, 1'b0, 1'b1);

        // Reset during HALTED.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_regs("rst_halted", 8'h00, 1'b0, 1'b0);
        tick(); chk_out("rst_h_t", 8'h00);

        // Reset during a stall.
        id_ready = 1'b0;
        tick(); chk_out("rst_st", 8'h00); chk_regs("rst_st", 8'h01, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0; id_ready = 1'b1;
        chk_regs("rst_stall", 8'h00, 1'b0, 1'b0);

        // Reset mid-stream.
        push(8'h00);
        tick(); tick();
        chk_out("rst_ms", 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_regs("rst_mid", 8'h00, 1'b0, 1'b0);
        chk("rst_mid_if_pc", {24'h0, if_pc}, 32'h0);

        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Program-counter and fetch-register stage sitting directly upstream of the 256×8 instruction ROM. It drives the ROM address `pc`, samples the combinationally returned `instruction`, and hands it downstream through a one-entry IF/ID register with a valid/ready handshake. It supports back-pressure, branch/jump redirect with flush, and a halt/drain sequence.

## Interface
- `PC_WIDTH`, 8, address width; must match the ROM address width.
- `INSTR_WIDTH`, 8, instruction width.
- `RESET_PC`, 8'h00, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc`  out  PC_WIDTH  ROM address, driven directly from the PC register.
- `instruction`  in  INSTR_WIDTH  ROM data for `pc`, valid in the same cycle (combinational read).
- `if_instr`  out  INSTR_WIDTH  captured instruction.
- `if_pc`  out  PC_WIDTH  address the `if_instr` was fetched from.
- `if_valid`  out  1  `if_instr`/`if_pc` hold an unconsumed instruction.
- `id_ready`  in  1  downstream accepts this cycle.
- `redirect`  in  1  load `redirect_pc` and flush the IF/ID register.
- `redirect_pc`  in  PC_WIDTH  redirect target.
- `halt`  in  1  request to stop fetching.
- `halted`  out  1  the stage is in HALTED.

## Operation
- **Reset (synchronous, rising edge with `reset`=1):** `pc`=RESET_PC, `if_instr`=0, `if_pc`=0, `if_valid`=0, `halted`=0, state=RUN. Reset overrides every other input.
- **Transfer:** occurs at an edge where `if_valid`&`id_ready`=1.
- **Capture condition (RUN only):** `!if_valid | id_ready`.
  - On capture: `if_instr`<=`instruction`, `if_pc`<=`pc`, `if_valid`<=1, `pc`<=`pc`+1 modulo 2^PC_WIDTH (8'hFF wraps to 8'h00, no flag).
- **Stall:** `if_valid`=1 and `id_ready`=0. The PC and IF/ID register hold; outputs stay stable.
- **Redirect (priority over halt and capture):**
  - `pc`<=`redirect_pc`, `if_valid`<=0. No capture occurs this edge.
  - Any transfer at the same edge still counts as consumed.
  - State<=RUN from any state.
- **FSM:**
  - **RUN:** normal fetch. If `halt`=1 and `redirect`=0: no capture at this edge; state<=DRAIN. A transfer at this edge still clears `if_valid`.
  - **DRAIN:** no capture; `pc` holds. When `if_valid`=0, or a transfer occurs, at the edge: `if_valid`<=0, state<=HALTED.
  - **HALTED:** `halted`=1, no capture, `pc` holds at the next unfetched address. `halt` is ignored. Only `redirect` (to RUN) or `reset` leaves this state.
- `halt` in DRAIN or HALTED has no further effect. `id_ready` is ignored while `if_valid`=0.

## Timing
- Fetch latency: `pc`=A in cycle n gives `if_instr`=rom[A], `if_valid`=1 in cycle n+1.
- Steady streaming with `id_ready`=1: one instruction per cycle, no bubbles.
- Redirect in cycle n:
  - `pc`=target and `if_valid`=0 in n+1.
  - rom[target] valid in n+2.
  - One bubble cycle.
- Halt in cycle n (RUN), with `if_valid` cleared by then: DRAIN in n+1, `halted`=1 in n+2 at the earliest. Under stall, `halted` rises on the cycle after the transfer.
- Stall introduces no added latency: the held instruction transfers on the first edge with `id_ready`=1, and the capture happens on that same edge.
- All outputs are registered except `pc`, which is also a register output.

## Test plan
- **Reset then stream:** ROM[0..3]=8'h11,22,33,44, `id_ready`=1 -> cycles 1..4 after reset release show `if_instr`=11,22,33,44 and `if_pc`=0..3, with `if_valid` continuously 1.
- **Back-pressure:** drop `id_ready` for 3 cycles while `if_instr`=8'h22 -> `if_instr`=22, `if_pc`=1 and `pc`=2 are held for 3 cycles. 8'h33 appears the cycle after `id_ready` returns, with no duplicate or lost instruction.
- **Wrap-around:** redirect to 8'hFE -> `if_pc` sequence FE, FF, 00, 01 with correct ROM data.
- **Redirect under stall:** `if_valid`=1, `id_ready`=0, redirect to 8'h80 -> `if_valid`=0 next cycle, `pc`=80, then `if_pc`=80 with rom[80]. The stalled instruction is never transferred.
- **Halt/drain/resume:** halt with a stalled instruction at `if_pc`=5 -> `halted` stays 0 until `id_ready` consumes it, then `halted`=1 with `pc`=6 frozen for 10+ cycles. A redirect to 8'h06 then resumes: `if_pc`=6, `halted`=0.
- **Simultaneous and reset mid-operation:**
  - `halt`+`redirect` in the same cycle -> redirect wins and the state stays RUN.
  - `reset` asserted mid-stream, during a stall, or during HALTED -> next cycle `pc`=RESET_PC, `if_valid`=0, `halted`=0.
